// File: rtl/meter_pkg.sv
// rtl/meter_pkg.sv - shared state encoding and default constants for the parking meter
package meter_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      RUNNING = 2'd1,
      EXPIRED = 2'd2
   } meter_state_t;

   localparam int SHORT_SEC_DEF = 60;
   localparam int LONG_SEC_DEF  = 180;
   localparam int MAX_SEC_DEF   = 9999;
   localparam int LOW_SEC_DEF   = 30;
   localparam int CNT_W_DEF     = 14;
   localparam int BCD_W         = 4;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to four-digit BCD converter
module bin2bcd_seq
   import meter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] bin,
   input  logic             start,
   output logic             busy,
   output logic [BCD_W-1:0] digit3,
   output logic [BCD_W-1:0] digit2,
   output logic [BCD_W-1:0] digit1,
   output logic [BCD_W-1:0] digit0
);

   localparam int SR_W   = 4*BCD_W + CNT_W;
   localparam int CNT_CW = $clog2(CNT_W + 1);
   localparam logic [CNT_CW-1:0] LAST_SHIFT = CNT_CW'(CNT_W);

   // BCD field sits above the binary field; binary bits shift into it
   logic [SR_W-1:0]   sr;
   logic [SR_W-1:0]   sr_adj;
   logic [CNT_CW-1:0] cnt;

   // add-3 correction on every BCD nibble that is 5 or more before each shift
   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < 4; i++) begin
         if (sr[CNT_W + BCD_W*i +: BCD_W] >= BCD_W'(5))
            sr_adj[CNT_W + BCD_W*i +: BCD_W] = sr[CNT_W + BCD_W*i +: BCD_W] + BCD_W'(3);
      end
   end

   // load, CNT_W shifts, then publish all digits at once so no partial value shows
   always_ff @(posedge clk) begin
      if (rst) begin
         sr     <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         digit3 <= '0;
         digit2 <= '0;
         digit1 <= '0;
         digit0 <= '0;
      end else if (!busy) begin
         if (start) begin
            sr   <= {{(4*BCD_W){1'b0}}, bin};
            cnt  <= '0;
            busy <= 1'b1;
         end
      end else if (cnt == LAST_SHIFT) begin
         digit3 <= sr[CNT_W + 3*BCD_W +: BCD_W];
         digit2 <= sr[CNT_W + 2*BCD_W +: BCD_W];
         digit1 <= sr[CNT_W + 1*BCD_W +: BCD_W];
         digit0 <= sr[CNT_W +: BCD_W];
         busy   <= 1'b0;
      end else begin
         sr  <= {sr_adj[SR_W-2:0], 1'b0};
         cnt <= cnt + CNT_CW'(1);
      end
   end

endmodule

// File: rtl/meter_controller.sv
// rtl/meter_controller.sv - parking meter credit/occupancy core; option METER_CLEAR_ON_LEAVE_EN
module meter_controller
   import meter_pkg::*;
#(
   parameter int SHORT_SEC = SHORT_SEC_DEF,
   parameter int LONG_SEC  = LONG_SEC_DEF,
   parameter int MAX_SEC   = MAX_SEC_DEF,
   parameter int LOW_SEC   = LOW_SEC_DEF,
   parameter int CNT_W     = CNT_W_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       parked,
   input  logic       add_short,
   input  logic       add_long,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic       expired,
   output logic       low_time,
   output logic [1:0] state
);

   localparam logic [CNT_W-1:0] SHORT_V = CNT_W'(SHORT_SEC);
   localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(LONG_SEC);
   localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_SEC);
   localparam logic [CNT_W-1:0] LOW_V   = CNT_W'(LOW_SEC);

   meter_state_t     state_q;
   meter_state_t     state_next;
   logic [CNT_W-1:0] credit;
   logic [CNT_W-1:0] credit_next;
   logic [CNT_W-1:0] last_bin;
   logic             first_q;
   logic             conv_start;
   logic             conv_busy;

`ifdef METER_CLEAR_ON_LEAVE_EN
   logic parked_q;

   // remember last sensor level so a departure can be detected
   always_ff @(posedge clk) begin
      if (rst) parked_q <= 1'b0;
      else     parked_q <= parked;
   end
`endif

   // credit update: add purchases, saturate, then take one second off on tick
   always_comb begin
      credit_next = credit + (add_short ? SHORT_V : '0) + (add_long ? LONG_V : '0);
      if (credit_next > MAX_V)
         credit_next = MAX_V;
      if (tick && credit_next != '0)
         credit_next = credit_next - CNT_W'(1);
`ifdef METER_CLEAR_ON_LEAVE_EN
      if (parked_q && !parked)
         credit_next = '0;
`endif
   end

   // next occupancy state follows next credit and the sensor directly
   always_comb begin
      state_next = EMPTY;
      if (credit_next != '0)
         state_next = RUNNING;
      else if (parked)
         state_next = EXPIRED;
   end

   // credit/state registers and the bookkeeping that decides when to re-convert
   always_ff @(posedge clk) begin
      if (rst) begin
         credit   <= '0;
         state_q  <= EMPTY;
         last_bin <= '0;
         first_q  <= 1'b1;
      end else begin
         credit  <= credit_next;
         state_q <= state_next;
         if (conv_start) begin
            last_bin <= credit;
            first_q  <= 1'b0;
         end
      end
   end

   assign conv_start = !conv_busy && (first_q || credit != last_bin);

   bin2bcd_seq #(
      .CNT_W (CNT_W)
   ) u_conv (
      .clk    (clk),
      .rst    (rst),
      .bin    (credit),
      .start  (conv_start),
      .busy   (conv_busy),
      .digit3 (digit3),
      .digit2 (digit2),
      .digit1 (digit1),
      .digit0 (digit0)
   );

   assign state    = state_q;
   assign expired  = (state_q == EXPIRED);
   assign low_time = (state_q == RUNNING) && (credit <= LOW_V);

endmodule

// File: tb/tb_meter_controller.sv
// tb/tb_meter_controller.sv - scoreboard bench for meter_controller
module tb_meter_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       parked;
   logic       add_short;
   logic       add_long;
   logic [3:0] digit3;
   logic [3:0] digit2;
   logic [3:0] digit1;
   logic [3:0] digit0;
   logic       expired;
   logic       low_time;
   logic [1:0] state;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic        req          = 1'b0;
   string       q_name[$];
   logic [19:0] q_exp[$];
   logic [19:0] act;
   logic [19:0] exp_v;
   string       nm;

   meter_controller dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .parked    (parked),
      .add_short (add_short),
      .add_long  (add_long),
      .digit3    (digit3),
      .digit2    (digit2),
      .digit1    (digit1),
      .digit0    (digit0),
      .expired   (expired),
      .low_time  (low_time),
      .state     (state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // monitor: compare DUT outputs against the oldest queued expectation
   always @(negedge clk) begin
      if (req) begin
         act = {digit3, digit2, digit1, digit0, state, expired, low_time};
         tests_run++;
         if (q_exp.size() == 0) begin
            tests_failed++;
            $display("FAIL monitor: sample requested with empty expectation queue, got %h", act);
         end else begin
            nm    = q_name.pop_front();
            exp_v = q_exp.pop_front();
            if (act !== exp_v) begin
               tests_failed++;
               $display("FAIL %s: got digits=%h state=%0d expired=%b low_time=%b, expected digits=%h state=%0d expired=%b low_time=%b",
                        nm, act[19:4], act[3:2], act[1], act[0],
                        exp_v[19:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
         end
      end
   end

   task automatic check(input string n, input logic [15:0] d, input logic [1:0] st,
                        input logic e, input logic l);
      q_name.push_back(n);
      q_exp.push_back({d, st, e, l});
      req = 1'b1;
      @(negedge clk);
      #1;
      req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic s, input logic l, input logic t);
      @(posedge clk);
      #1;
      add_short = s;
      add_long  = l;
      tick      = t;
      @(posedge clk);
      #1;
      add_short = 1'b0;
      add_long  = 1'b0;
      tick      = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      tick      = 1'b0;
      parked    = 1'b0;
      add_short = 1'b0;
      add_long  = 1'b0;
      idle(3);
      check("reset_state", 16'h0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(40);
      check("idle_after_reset", 16'h0000, 2'd0, 1'b0, 1'b0);

      parked = 1'b1;
      pulse(1'b1, 1'b0, 1'b0);
      idle(40);
      check("short_60", 16'h0060, 2'd1, 1'b0, 1'b0);
      ticks(29);
      idle(40);
      check("credit_31_not_low", 16'h0031, 2'd1, 1'b0, 1'b0);
      ticks(1);
      idle(40);
      check("credit_30_low", 16'h0030, 2'd1, 1'b0, 1'b1);
      ticks(1);
      idle(40);
      check("credit_29_low", 16'h0029, 2'd1, 1'b0, 1'b1);
      ticks(29);
      idle(40);
      check("expired", 16'h0000, 2'd2, 1'b1, 1'b0);
      ticks(1);
      idle(40);
      check("no_wrap_at_zero", 16'h0000, 2'd2, 1'b1, 1'b0);
      parked = 1'b0;
      idle(2);
      check("left_empty", 16'h0000, 2'd0, 1'b0, 1'b0);

      pulse(1'b1, 1'b1, 1'b1);
      idle(15);
      check("digits_before_latency", 16'h0000, 2'd1, 1'b0, 1'b0);
      idle(1);
      check("digits_239_at_latency", 16'h0239, 2'd1, 1'b0, 1'b0);

      for (int i = 0; i < 56; i++) pulse(1'b0, 1'b1, 1'b0);
      ticks(9);
      idle(40);
      check("preload_9990", 16'h9990, 2'd1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      idle(40);
      check("sat_long_9999", 16'h9999, 2'd1, 1'b0, 1'b0);
      ticks(9);
      pulse(1'b0, 1'b1, 1'b1);
      idle(40);
      check("sat_long_tick_9998", 16'h9998, 2'd1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      idle(40);
      check("sat_short_9999", 16'h9999, 2'd1, 1'b0, 1'b0);
      pulse(1'b1, 1'b1, 1'b0);
      idle(40);
      check("sat_both_9999", 16'h9999, 2'd1, 1'b0, 1'b0);

      ticks(1);
      idle(5);
      rst = 1'b1;
      idle(1);
      check("reset_mid_conversion", 16'h0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      idle(40);
      check("conversion_after_reset", 16'h0000, 2'd0, 1'b0, 1'b0);

      parked = 1'b1;
      pulse(1'b0, 1'b1, 1'b0);
      ticks(80);
      idle(40);
      check("credit_100", 16'h0100, 2'd1, 1'b0, 1'b0);
      parked = 1'b0;
      idle(40);
`ifdef METER_CLEAR_ON_LEAVE_EN
      check("leave_clears", 16'h0000, 2'd0, 1'b0, 1'b0);
`else
      check("leave_keeps", 16'h0100, 2'd1, 1'b0, 1'b0);
`endif

      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/meter_controller.md
# meter_controller

Sequencing core of the parking meter: holds paid credit in seconds, accepts credit-purchase pulses, counts credit down on the 1 Hz tick, and tracks occupancy state from the sensor. Sits between the debounced button/sensor inputs and `display_control`, supplying the four BCD digits and the expired/low-time flags that drive display blinking. Replaces the free-running `second_counter` as the owner of the time value.

## Interface
- `SHORT_SEC`, 60: seconds credited per `add_short` pulse
- `LONG_SEC`, 180: seconds credited per `add_long` pulse
- `MAX_SEC`, 9999: credit saturation ceiling, the largest 4-digit decimal value
- `LOW_SEC`, 30: `low_time` asserted while 0 < credit ≤ LOW_SEC
- `CNT_W`, 14: credit register width; must satisfy 2^CNT_W > MAX_SEC + LONG_SEC + SHORT_SEC

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `tick`  in  1  one-`clk`-cycle pulse at 1 Hz, in the `clk` domain
- `parked`  in  1  level from `sensor`; 1 = car present
- `add_short`  in  1  one-cycle purchase pulse, already edge-detected
- `add_long`  in  1  one-cycle purchase pulse, already edge-detected
- `digit3`..`digit0`  out  4 each  BCD credit; `digit3` is the thousands digit
- `expired`  out  1  state == EXPIRED
- `low_time`  out  1  RUNNING and credit ≤ LOW_SEC
- `state`  out  2  EMPTY=0, RUNNING=1, EXPIRED=2

## Operation
- Credit register `credit[CNT_W-1:0]`. Per-cycle update order:
  1. `sum = credit + (add_short ? SHORT_SEC : 0) + (add_long ? LONG_SEC : 0)`.
  2. Saturate: `sum = min(sum, MAX_SEC)`.
  3. If `tick` and `sum > 0`, then `sum = sum - 1`.
  4. Register the result.
- Both add pulses in the same cycle both credit. An add coinciding with `tick` credits first, then decrements.
- Credit counts down whenever it is nonzero, regardless of `parked`.
- State is a registered function of next credit and `parked`:
  - RUNNING if credit > 0.
  - EXPIRED if credit == 0 and `parked`.
  - EMPTY if credit == 0 and not `parked`.
  - Transitions follow directly (RUNNING→EXPIRED when the last second elapses with a car present, EXPIRED→EMPTY on departure, any→RUNNING on purchase). The encoding value 3 is never produced.
- BCD conversion is done by the `bin2bcd_seq` sub-module, a sequential double-dabble:
  - Starts when it is idle and `credit` differs from the last converted value, or on the first cycle after reset.
  - Takes CNT_W shift cycles, then loads all four digits in one cycle.
  - Digits never show a partially converted value. A credit change mid-conversion is picked up by the next conversion.
- Reset mid-operation: all registers cleared on the next edge. An in-flight conversion is aborted.

## Timing
- Reset values: `credit`=0, `state`=EMPTY, `digit3..0`=0, `expired`=0, `low_time`=0, converter idle.
- `credit`, `state`, `expired`, `low_time`: 1-cycle latency from inputs.
- Digits: valid exactly CNT_W+2 cycles after the `credit` edge (1 cycle to start, CNT_W shifts, 1 cycle to load), when the converter was idle. Worst case is 2·(CNT_W+2) cycles.
- Saturation: credit 9990 + `add_long` → 9999. With a simultaneous `tick` → 9998.
- Decrement at 0 never wraps.

## Configuration
- `METER_CLEAR_ON_LEAVE_EN`:
  - Defined: a `parked` 1→0 transition (registered edge detect) forces credit to 0 on the following cycle. This overrides any add or tick in that cycle. State goes to EMPTY.
  - Undefined: departure does not affect credit; remaining time stays for the next car.

## Structure
- Shared package `meter_pkg` holds:
  - The state encoding constants EMPTY/RUNNING/EXPIRED.
  - The default SHORT_SEC/LONG_SEC/MAX_SEC values.
  - The BCD digit width.
- One sub-module, `bin2bcd_seq`. Ports: `clk`, `rst`, `bin[CNT_W-1:0]`, `start`, `busy`, and four BCD outputs.

## Test plan
- Reset, then idle 40 cycles → credit 0, state EMPTY, digits 0000, `expired`=0.
- `parked`=1, one `add_short`, then 31 `tick`s → digits 0029, `low_time`=1 from 0030. After 29 more ticks: state EXPIRED, `expired`=1, digits 0000.
- `add_long` and `add_short` in the same cycle as a `tick` from credit 0 → credit 239, digits 0239 after 16 cycles.
- Preload 9990, then `add_long` → 9999; again with a simultaneous `tick` → 9998. Further adds keep the value at 9999.
- Credit 100, `parked` 1→0:
  - Macro defined → credit 0, state EMPTY.
  - Macro undefined → credit stays 100, state RUNNING.
- Assert `rst` for one cycle during a conversion → all outputs 0 next cycle. After reset deasserts, the conversion of 0 completes with digits 0000.
